// File: rtl/inv_syn_sched.sv
// Round-robin scheduler and serial engine for the DNA inverse-syndrome weighted sum.
// Build macro INV_SYN_MOD_EN: when defined, the accumulator is kept reduced modulo MOD.
module inv_syn_sched #(
   parameter int N   = 6,
   parameter int R   = 4,
   parameter int MOD = 25,
   localparam int IDW = (R > 1) ? $clog2(R) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [R-1:0]       req_valid,
   input  logic [R*2*N-1:0]   req_word,
   output logic [R-1:0]       req_ready,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [13:0]        res_sum,
   output logic [IDW-1:0]     res_id,
   output logic               busy
);
   localparam int KW = $clog2(N) + 1;
   localparam logic [R-1:0] ONE_R = {{(R-1){1'b0}}, 1'b1};
`ifdef INV_SYN_MOD_EN
   localparam int NSUB = (4*N + MOD - 1) / MOD + 1;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic [2*N-1:0]  r_word;
   logic [KW-1:0]   r_k;
   logic [13:0]     r_acc;
   logic            r_res_valid;
   logic [13:0]     r_res_sum;
   logic [IDW-1:0]  r_res_id;
   logic            r_busy;

   logic            w_found;
   logic [IDW-1:0]  w_gidx;
   logic [2:0]      w_digit;
   logic [13:0]     w_acc_next;

   // A zero digit stands for weight 4; other digits weigh their own value.
   function automatic logic [2:0] digit_val(input logic [1:0] d);
      logic [2:0] v;
      case (d)
         2'b00:   v = 3'd4;
         2'b01:   v = 3'd1;
         2'b10:   v = 3'd2;
         2'b11:   v = 3'd3;
         default: v = 3'd4;
      endcase
      return v;
   endfunction

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int i = 1; i <= R; i++) begin
         if (!w_found && req_valid[(int'(r_ptr) + i) % R]) begin
            w_found = 1'b1;
            w_gidx  = IDW'((int'(r_ptr) + i) % R);
         end else begin
            w_found = w_found;
         end
      end
   end

   // Grant pulse is only offered while idle.
   always_comb begin
      if (r_state == S_IDLE && w_found) begin
         req_ready = ONE_R << w_gidx;
      end else begin
         req_ready = '0;
      end
   end

   // Next accumulator value, optionally folded back below MOD.
   always_comb begin
      w_digit    = digit_val(r_word[1:0]);
      w_acc_next = r_acc + 14'(w_digit) * 14'(r_k + 1'b1);
`ifdef INV_SYN_MOD_EN
      for (int j = 0; j < NSUB; j++) begin
         if (w_acc_next >= 14'(MOD)) begin
            w_acc_next = w_acc_next - 14'(MOD);
         end else begin
            w_acc_next = w_acc_next;
         end
      end
`endif
   end

   // Control FSM with the shift/accumulate datapath and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= IDW'(R - 1);
         r_id        <= '0;
         r_word      <= '0;
         r_k         <= '0;
         r_acc       <= 14'd0;
         r_res_valid <= 1'b0;
         r_res_sum   <= 14'd0;
         r_res_id    <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_word  <= req_word[int'(w_gidx)*(2*N) +: 2*N];
                  r_id    <= w_gidx;
                  r_ptr   <= w_gidx;
                  r_acc   <= 14'd0;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CALC: begin
               r_acc  <= w_acc_next;
               r_word <= {2'b00, r_word[2*N-1:2]};
               r_k    <= r_k + 1'b1;
               if (r_k == KW'(N - 1)) begin
                  r_res_valid <= 1'b1;
                  r_res_sum   <= w_acc_next;
                  r_res_id    <= r_id;
                  r_state     <= S_DONE;
               end else begin
                  r_state <= S_CALC;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_res_sum   <= 14'd0;
                  r_res_id    <= '0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_res_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign res_valid = r_res_valid;
   assign res_sum   = r_res_sum;
   assign res_id    = r_res_id;
   assign busy      = r_busy;

endmodule
